// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
//
// Loads a program into instruction memory from a byte stream (UART or debug
// link). The block owns the memory address and write port. While idle it
// passes the CPU fetch PC through to the memory. During a load it drives the
// memory itself and stalls the CPU.
//
// Bytes are assembled little-endian into 32-bit words. Each complete word is
// written in a single WRITE cycle. Word addresses wrap modulo the memory
// depth, so a load longer than the memory overwrites it again from address 0.
//
// Optional feature, enabled by defining IMEM_CHECKSUM_EN:
//   After the last data word, one more 4-byte word is collected as a
//   checksum. It is compared against the 32-bit sum of all data words. On a
//   mismatch, load_error is set and stays set until the next accepted
//   load_start. With the macro undefined there is no CHECK state and no
//   load_error port.
//
// Parameters
//   INSTR_BYTES  instruction memory size in bytes (power of 2)
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   load_start   1-cycle pulse that starts a load (honoured only when idle)
//   load_words   number of 32-bit words to load, sampled with load_start
//   byte_valid   byte_data is valid
//   byte_data    program byte, little-endian within each word
//   byte_ready   loader accepts a byte (transfer = byte_valid & byte_ready)
//   cpu_pc       CPU fetch address
//   mem_addr     byte address to instruction memory
//   mem_we       instruction memory write enable
//   mem_wdata    instruction memory write data
//   cpu_stall    hold CPU PC/pipeline while loading
//   busy         load in progress
//   done         1-cycle pulse when a load completes
//   load_error   checksum mismatch flag (IMEM_CHECKSUM_EN only)
// -----------------------------------------------------------------------------
module imem_boot_loader #(
    parameter int unsigned INSTR_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_start,
    input  logic [15:0] load_words,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic [31:0] cpu_pc,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic        cpu_stall,
    output logic        busy,
`ifdef IMEM_CHECKSUM_EN
    output logic        load_error,
`endif
    output logic        done
);

    localparam int unsigned ADDR_BITS = $clog2(INSTR_BYTES / 4);

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StWrite,
`ifdef IMEM_CHECKSUM_EN
        StCheck,
`endif
        StDone
    } state_e;

    state_e state_q, state_d;
    state_e after_data;  // state that follows the last data word (or an empty load)

    logic [15:0] load_words_q, load_words_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [15:0] word_next;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] asm_q, asm_d;
    logic        xfer;
    logic        word_complete;

`ifdef IMEM_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
    logic        load_error_q, load_error_d;
    assign after_data = StCheck;
    assign load_error = load_error_q;
`else
    assign after_data = StDone;
`endif

    assign xfer          = byte_valid & byte_ready;
    assign word_complete = xfer & (byte_cnt_q == 2'd3);
    assign word_next     = word_idx_q + 16'd1;

    // ---------------------------------------------------------------- FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (load_start) begin
                    state_d = (load_words == 16'd0) ? after_data : StCollect;
                end
            end
            StCollect: begin
                if (word_complete) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                // 16-bit compare: word_idx wraps with load_words, not with the memory size
                state_d = (word_next == load_words_q) ? after_data : StCollect;
            end
`ifdef IMEM_CHECKSUM_EN
            StCheck: begin
                if (word_complete) begin
                    state_d = StDone;
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ---------------------------------------------------------------- FSM outputs
    always_comb begin
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        done       = 1'b0;
        busy       = (state_q != StIdle);
        cpu_stall  = (state_q != StIdle);
        mem_wdata  = asm_q;
        if (state_q == StIdle) begin
            mem_addr = cpu_pc;
        end else begin
            mem_addr = {{(30 - ADDR_BITS){1'b0}}, word_idx_q[ADDR_BITS-1:0], 2'b00};
        end
        unique case (state_q)
            StCollect: byte_ready = 1'b1;
            StWrite:   mem_we     = 1'b1;
`ifdef IMEM_CHECKSUM_EN
            StCheck:   byte_ready = 1'b1;
`endif
            StDone:    done       = 1'b1;
            default: begin
            end
        endcase
    end

    // ---------------------------------------------------------------- datapath next state
    always_comb begin
        load_words_d = load_words_q;
        word_idx_d   = word_idx_q;
        byte_cnt_d   = byte_cnt_q;
        asm_d        = asm_q;
`ifdef IMEM_CHECKSUM_EN
        sum_d        = sum_q;
        load_error_d = load_error_q;
`endif
        if ((state_q == StIdle) && load_start) begin
            load_words_d = load_words;
            word_idx_d   = 16'd0;
            byte_cnt_d   = 2'd0;
            asm_d        = 32'd0;
`ifdef IMEM_CHECKSUM_EN
            sum_d        = 32'd0;
            load_error_d = 1'b0;
`endif
        end
        if (xfer) begin
            asm_d[{byte_cnt_q, 3'b000} +: 8] = byte_data;
            byte_cnt_d = byte_cnt_q + 2'd1;  // wraps to 0 after the fourth byte
        end
        if (state_q == StWrite) begin
            word_idx_d = word_next;
`ifdef IMEM_CHECKSUM_EN
            sum_d      = sum_q + asm_q;
`endif
        end
`ifdef IMEM_CHECKSUM_EN
        if ((state_q == StCheck) && word_complete) begin
            if ({byte_data, asm_q[23:0]} != sum_q) begin
                load_error_d = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_words_q <= 16'd0;
            word_idx_q   <= 16'd0;
            byte_cnt_q   <= 2'd0;
            asm_q        <= 32'd0;
`ifdef IMEM_CHECKSUM_EN
            sum_q        <= 32'd0;
            load_error_q <= 1'b0;
`endif
        end else begin
            load_words_q <= load_words_d;
            word_idx_q   <= word_idx_d;
            byte_cnt_q   <= byte_cnt_d;
            asm_q        <= asm_d;
`ifdef IMEM_CHECKSUM_EN
            sum_q        <= sum_d;
            load_error_q <= load_error_d;
`endif
        end
    end

endmodule
